dpram_req_sched: RTL and testbench

- Request scheduler that sits directly upstream of the 64x8 dual-port RAM and drives all of its port-A and port-B strobes.
- Exposes two independent valid/ready request channels: channel A maps to RAM port A, channel B maps to RAM port B.
- Resolves same-address conflicts between the two channels.
- Collects the RAM's 1-cycle registered read data into per-channel response FIFOs with backpressure.

---
 rtl/dpram_req_sched.sv | 142 ++++++++++++++
 tb/tb_dpram_req_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_req_sched.sv
// dpram_req_sched: two valid/ready request channels onto a 64x8 dual-port RAM, A-priority address-conflict stall, per-channel read response FIFOs.
// Latency: RAM strobes in the accept cycle; read response valid 2 edges after accept (RAM register + FIFO push).
// Backpressure: a channel stops accepting reads once RSP_DEPTH reads are unpopped; writes always accepted (B also stalls on conflict).
module dpram_req_sched #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  // channel A
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  input  logic              a_rsp_ready,
  output logic [DATA_W-1:0] a_rsp_data,
  // channel B
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,
  output logic [DATA_W-1:0] b_rsp_data,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_data_b,
  output logic              ram_we_b,
  output logic              ram_re_a,
  output logic              ram_re_b,
  input  logic [DATA_W-1:0] ram_q_a,
  input  logic [DATA_W-1:0] ram_q_b,
  output logic [7:0]        conflict_cnt
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int PW = $clog2(RSP_DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(RSP_DEPTH);

  // credit counters: reads accepted but not yet popped (includes the one in the RAM)
  logic [CW-1:0] cnt_a, cnt_b;
  logic          a_acc, b_acc, a_rd_acc, b_rd_acc, conflict;
  logic          a_inflight, b_inflight;
  logic          a_pop, b_pop;

  // response FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [DATA_W-1:0] mem_a [RSP_DEPTH];
  logic [DATA_W-1:0] mem_b [RSP_DEPTH];
  logic [PW:0]       wp_a, rp_a, wp_b, rp_b;

  // Channel A has fixed priority and never looks at channel B.
  assign a_req_ready = !rst && (a_req_we || (cnt_a < CRED_MAX));
  assign a_acc       = a_req_valid && a_req_ready;
  assign a_rd_acc    = a_acc && !a_req_we;

  // Same-address access involving a write would race across ports, so B waits.
  // Two reads of the same address are harmless and proceed together.
  assign conflict    = a_acc && (a_req_addr == b_req_addr) && (a_req_we || b_req_we);
  assign b_req_ready = !rst && (b_req_we || (cnt_b < CRED_MAX)) && !conflict;
  assign b_acc       = b_req_valid && b_req_ready;
  assign b_rd_acc    = b_acc && !b_req_we;

  // Address/data pass straight through; only the strobes are qualified.
  assign ram_addr_a = a_req_addr;
  assign ram_data_a = a_req_wdata;
  assign ram_addr_b = b_req_addr;
  assign ram_data_b = b_req_wdata;
  assign ram_we_a   = a_acc && a_req_we;
  assign ram_we_b   = b_acc && b_req_we;
  // The RAM has one read enable for both ports; the in-flight flags decide whose q is kept.
  assign ram_re_a   = a_rd_acc || b_rd_acc;
  assign ram_re_b   = ram_re_a;

  assign a_rsp_valid = (wp_a != rp_a);
  assign b_rsp_valid = (wp_b != rp_b);
  assign a_rsp_data  = mem_a[rp_a[PW-1:0]];
  assign b_rsp_data  = mem_b[rp_b[PW-1:0]];
  assign a_pop       = a_rsp_valid && a_rsp_ready;
  assign b_pop       = b_rsp_valid && b_rsp_ready;

  // Mark which channel's read data arrives from the RAM next cycle; reset drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_inflight <= 1'b0;
      b_inflight <= 1'b0;
    end else begin
      a_inflight <= a_rd_acc;
      b_inflight <= b_rd_acc;
    end
  end

  // Credit counters: +1 on read accept, -1 on pop, both in one cycle cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_rd_acc && !a_pop)      cnt_a <= cnt_a + CW'(1);
      else if (!a_rd_acc && a_pop) cnt_a <= cnt_a - CW'(1);
      if (b_rd_acc && !b_pop)      cnt_b <= cnt_b + CW'(1);
      else if (!b_rd_acc && b_pop) cnt_b <= cnt_b - CW'(1);
    end
  end

  // FIFO pointers; credits bound occupancy so no full check is needed on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_a <= '0;
      rp_a <= '0;
      wp_b <= '0;
      rp_b <= '0;
    end else begin
      if (a_inflight) wp_a <= wp_a + (PW+1)'(1);
      if (a_pop)      rp_a <= rp_a + (PW+1)'(1);
      if (b_inflight) wp_b <= wp_b + (PW+1)'(1);
      if (b_pop)      rp_b <= rp_b + (PW+1)'(1);
    end
  end

  // FIFO storage captures the RAM's registered read data; head is untouched until popped.
  always_ff @(posedge clk) begin
    if (a_inflight) mem_a[wp_a[PW-1:0]] <= ram_q_a;
    if (b_inflight) mem_b[wp_b[PW-1:0]] <= ram_q_b;
  end

  // Count cycles where B wanted to go but lost to A, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= 8'd0;
    end else if (b_req_valid && conflict && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dpram_req_sched.sv
// tb_dpram_req_sched: randomized and directed stimulus against a queue-based reference model of the scheduler plus a RAM.
// Latency: model predicts responses visible two edges after the accepting edge.
// Backpressure: model grants read credits from the count of unpopped responses per channel.
module tb_dpram_req_sched;

  logic       clk;
  logic       rst;
  logic       a_req_valid, a_req_ready, a_req_we;
  logic [5:0] a_req_addr;
  logic [7:0] a_req_wdata;
  logic       a_rsp_valid, a_rsp_ready;
  logic [7:0] a_rsp_data;
  logic       b_req_valid, b_req_ready, b_req_we;
  logic [5:0] b_req_addr;
  logic [7:0] b_req_wdata;
  logic       b_rsp_valid, b_rsp_ready;
  logic [7:0] b_rsp_data;
  logic [5:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_data_a, ram_data_b;
  logic       ram_we_a, ram_we_b, ram_re_a, ram_re_b;
  logic [7:0] ram_q_a, ram_q_b;
  logic [7:0] conflict_cnt;
  logic       ram_load;

  int n_vec = 0;
  int n_bad = 0;

  dpram_req_sched #(.DATA_W(8), .ADDR_W(6), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
    .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a),
    .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_we_b(ram_we_b),
    .ram_re_a(ram_re_a), .ram_re_b(ram_re_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b),
    .conflict_cnt(conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 64x8 dual-port RAM with registered read data, shared read enable
  logic [7:0] ram [64];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 64; i++) ram[i] <= 8'(i * 7 + 1);
    end else begin
      if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
      if (ram_we_b) ram[ram_addr_b] <= ram_data_b;
    end
    if (ram_re_a) ram_q_a <= ram[ram_addr_a];
    if (ram_re_b) ram_q_b <= ram[ram_addr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] d;
    int         vis;
  } rsp_t;

  rsp_t       qa[$];
  rsp_t       qb[$];
  logic [7:0] ref_mem [64];
  int         cc;
  int         cyc;
  bit         ea_rdy, eb_rdy, a_acc, b_acc, conf, eav, ebv;

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 7 + 1);
    cc  = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ea_rdy = 0; eb_rdy = 0; a_acc = 0; b_acc = 0; conf = 0;
      end else begin
        ea_rdy = a_req_we || (qa.size() < 4);
        a_acc  = a_req_valid && ea_rdy;
        conf   = a_acc && (a_req_addr == b_req_addr) && (a_req_we || b_req_we);
        eb_rdy = (b_req_we || (qb.size() < 4)) && !conf;
        b_acc  = b_req_valid && eb_rdy;
      end
      eav = (qa.size() > 0) && (qa[0].vis <= cyc);
      ebv = (qb.size() > 0) && (qb[0].vis <= cyc);

      chk("a_req_ready", a_req_ready, ea_rdy);
      chk("b_req_ready", b_req_ready, eb_rdy);
      chk("ram_we_a", ram_we_a, a_acc && a_req_we);
      chk("ram_we_b", ram_we_b, b_acc && b_req_we);
      chk("ram_re_a", ram_re_a, (a_acc && !a_req_we) || (b_acc && !b_req_we));
      chk("ram_re_b", ram_re_b, (a_acc && !a_req_we) || (b_acc && !b_req_we));
      chk("ram_addr_a", ram_addr_a, a_req_addr);
      chk("ram_addr_b", ram_addr_b, b_req_addr);
      chk("ram_data_a", ram_data_a, a_req_wdata);
      chk("ram_data_b", ram_data_b, b_req_wdata);
      chk("a_rsp_valid", a_rsp_valid, eav);
      chk("b_rsp_valid", b_rsp_valid, ebv);
      if (eav) chk("a_rsp_data", a_rsp_data, qa[0].d);
      if (ebv) chk("b_rsp_data", b_rsp_data, qb[0].d);
      chk("conflict_cnt", conflict_cnt, cc);

      // apply what the upcoming edge does
      if (rst) begin
        qa.delete();
        qb.delete();
        cc = 0;
      end else begin
        if (eav && a_rsp_ready) void'(qa.pop_front());
        if (ebv && b_rsp_ready) void'(qb.pop_front());
        if (a_acc && !a_req_we) qa.push_back('{d: ref_mem[a_req_addr], vis: cyc + 2});
        if (b_acc && !b_req_we) qb.push_back('{d: ref_mem[b_req_addr], vis: cyc + 2});
        if (a_acc && a_req_we) ref_mem[a_req_addr] = a_req_wdata;
        if (b_acc && b_req_we) ref_mem[b_req_addr] = b_req_wdata;
        if (b_req_valid && conf && cc < 255) cc++;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  int n_acc;
  int got;

  initial begin
    rst = 1'b1; ram_load = 1'b1;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 6'd0; a_req_wdata = 8'd0;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 6'd0; b_req_wdata = 8'd0;
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;

    // reset with requests pending
    repeat (2) begin
      @(negedge clk);
      chk("rst_a_ready", a_req_ready, 0);
      chk("rst_b_ready", b_req_ready, 0);
      chk("rst_strobes", {ram_we_a, ram_we_b, ram_re_a, ram_re_b}, 0);
      chk("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
      chk("rst_conflict_cnt", conflict_cnt, 0);
    end
    tick();
    rst = 1'b0; ram_load = 1'b0;
    idle();
    tick();

    // write addr 5 on A, then read it on both channels
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 6'd5; a_req_wdata = 8'h3C;
    tick();
    a_req_we = 1'b0;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 6'd5;
    @(negedge clk);
    chk("wr_rd_a_ready", a_req_ready, 1);
    chk("wr_rd_b_ready", b_req_ready, 1);
    tick();
    idle();
    @(negedge clk);
    chk("rd_lat_inflight", {a_rsp_valid, b_rsp_valid}, 0);
    tick();
    @(negedge clk);
    chk("rd_lat_a_valid", a_rsp_valid, 1);
    chk("rd_lat_b_valid", b_rsp_valid, 1);
    chk("rd_a_data_3c", a_rsp_data, 8'h3C);
    chk("rd_b_data_3c", b_rsp_data, 8'h3C);
    tick();

    // write/write conflict on addr 9
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 6'd9; a_req_wdata = 8'h11;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 6'd9; b_req_wdata = 8'h22;
    @(negedge clk);
    chk("conf_b_stalled", b_req_ready, 0);
    chk("conf_a_ready", a_req_ready, 1);
    tick();
    a_req_valid = 1'b0;
    @(negedge clk);
    chk("conf_cnt_1", conflict_cnt, 1);
    chk("conf_b_retry_ready", b_req_ready, 1);
    tick();
    // same-address reads right after B's write
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 6'd9;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 6'd9;
    @(negedge clk);
    chk("rr_same_ready", {a_req_ready, b_req_ready}, 2'b11);
    tick();
    idle();
    tick();
    @(negedge clk);
    chk("rr_a_data_22", a_rsp_data, 8'h22);
    chk("rr_b_data_22", b_rsp_data, 8'h22);
    chk("rr_conf_cnt", conflict_cnt, 1);
    tick();
    tick();

    // backpressure on A: 6 reads, only 4 credits
    a_rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 6'(10 + i);
      @(negedge clk);
      chk("bp_ready", a_req_ready, (i < 4) ? 1 : 0);
      if (a_req_ready) n_acc++;
      tick();
    end
    chk("bp_accepted", n_acc, 4);
    a_req_we = 1'b1; a_req_addr = 6'd20; a_req_wdata = 8'h55;
    @(negedge clk);
    chk("bp_write_ready", a_req_ready, 1);
    tick();
    idle();
    a_rsp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && got < 4; k++) begin
      @(negedge clk);
      if (a_rsp_valid) begin
        chk("bp_drain_data", a_rsp_data, 8'(71 + 7 * got));
        got++;
      end
    end
    chk("bp_drain_count", got, 4);
    tick();
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 6'd3;
    @(negedge clk);
    chk("bp_unblock", a_req_ready, 1);
    tick();
    idle();
    tick(); tick();

    // reset the cycle after a read accept
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 6'd30;
    tick();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_rst_rsp_valid", a_rsp_valid, 0);
    tick();
    rst = 1'b0;
    a_rsp_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mr_no_rsp", a_rsp_valid, 0);
    end
    tick();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 6'(40 + i);
      @(negedge clk);
      if (a_req_ready) n_acc++;
      tick();
    end
    chk("mr_credits", n_acc, 4);
    idle();
    a_rsp_ready = 1'b1;
    repeat (8) tick();

    // conflict counter saturation
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 6'd1; a_req_wdata = 8'hA5;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 6'd1; b_req_wdata = 8'h5A;
    repeat (10) tick();
    @(negedge clk);
    chk("sat_cnt_10", conflict_cnt, 10);
    repeat (250) tick();
    idle();
    @(negedge clk);
    chk("sat_cnt_255", conflict_cnt, 255);
    tick();

    // randomized traffic, small address range to provoke conflicts
    repeat (3000) begin
      rst         = ($urandom_range(0, 199) == 0);
      a_req_valid = ($urandom_range(0, 99) < 70);
      a_req_we    = ($urandom_range(0, 99) < 35);
      a_req_addr  = 6'($urandom_range(0, 7));
      a_req_wdata = 8'($urandom);
      b_req_valid = ($urandom_range(0, 99) < 70);
      b_req_we    = ($urandom_range(0, 99) < 35);
      b_req_addr  = 6'($urandom_range(0, 7));
      b_req_wdata = 8'($urandom);
      a_rsp_ready = ($urandom_range(0, 99) < 70);
      b_rsp_ready = ($urandom_range(0, 99) < 60);
      tick();
    end
    rst = 1'b0;
    idle();
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
